// File: rtl/ex_mul_unit.sv
// EX-stage radix-2 shift-add multiplier with a valid/ready handshake on both sides.
// It raises freeze while an operation is in flight so the ID-stage register can be held.
module ex_mul_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               freeze
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mplier;
  logic [WIDTH-1:0]  acc;
  logic              neg;

  logic              accept;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  acc_nxt;
  logic [WIDTH-1:0]  mplier_nxt;
  logic [PW-1:0]     product;
  logic [PW-1:0]     signed_product;

  // Handshake and pipeline-hold flags decoded from state and the consumer's ready
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign freeze   = (state == BUSY) | ((state == DONE) & ~out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned
  assign a_mag = (in_signed & in_a[WIDTH-1]) ? -in_a : in_a;
  assign b_mag = (in_signed & in_b[WIDTH-1]) ? -in_b : in_b;

  // One shift-add step: conditional add into the upper half, then shift the pair right with carry-in
  always_comb begin
    sum            = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nxt        = sum[WIDTH:1];
    mplier_nxt     = {sum[0], mplier[WIDTH-1:1]};
    product        = {acc_nxt, mplier_nxt};
    signed_product = neg ? -product : product;
  end

  // Control FSM and datapath registers; flush overrides everything, accept overrides the DONE exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          count  <= count - CW'(1);
          if (count == '0) begin
            result    <= signed_product;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
      if (accept) begin
        mcand     <= a_mag;
        mplier    <= b_mag;
        neg       <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        acc       <= '0;
        count     <= CW'(WIDTH - 1);
        state     <= BUSY;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit: directed corner cases plus a randomized run,
// all compared every cycle against a transaction-level model of the multiplier.
module tb_ex_mul_unit;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           in_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] result;
  logic           freeze;

  int n_tests = 0;
  int n_fail  = 0;

  ex_mul_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .freeze(freeze)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product straight from integer arithmetic
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Transaction model: an accepted pair becomes a valid result W edges later
  bit          m_busy  = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_rdy;
  int          m_edges = 0;
  logic [63:0] m_pend  = '0;
  logic [63:0] m_res   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_edges = 0;
    end else begin
      m_rdy = !m_busy && (!m_valid || out_ready);
      if (flush) begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
      end else begin
        if (m_busy) begin
          m_edges++;
          if (m_edges == W) begin
            m_busy  = 1'b0;
            m_valid = 1'b1;
            m_res   = m_pend;
          end
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
        if (in_valid && m_rdy) begin
          m_busy  = 1'b1;
          m_edges = 0;
          m_pend  = ref_mul(in_a, in_b, in_signed);
          m_valid = 1'b0;
        end
      end
    end
  end

  // Compare process, sampled away from the rising edge after inputs have settled
  always @(negedge clk) begin
    #2;
    chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
    chk("cyc_freeze", 64'(freeze), 64'(m_busy || (m_valid && !out_ready)));
    chk("cyc_in_ready", 64'(in_ready), 64'(!m_busy && (!m_valid || out_ready)));
    if (m_valid) chk("cyc_result", result, m_res);
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic ordy);
    @(negedge clk);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = ordy;
    @(posedge clk);
    #1;
    chk("accept_freeze", 64'(freeze), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_signed = 1'($urandom);
  endtask

  // Counts rising edges since the accepting edge until out_valid shows up (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [63:0] exp, input string name);
    int lat;
    issue(a, b, s, 1'b1);
    wait_done(lat);
    chk({name, "_latency"}, 64'(lat), 64'd32);
    chk({name, "_result"}, result, exp);
    chk({name, "_model"}, ref_mul(a, b, s), exp);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int seen;

    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_freeze", 64'(freeze), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    op(32'd7, 32'd6, 1'b0, 64'd42, "u7x6");
    op(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s_m3x5");
    op(32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, "u_fffdx5");
    op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_minxmin");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_maxxmax");
    op(32'h0, 32'hFFFF_FFFF, 1'b1, 64'd0, "s_zero");

    // Consumer stall in DONE, then a back-to-back accept on the releasing edge
    issue(32'd11, 32'd13, 1'b0, 1'b0);
    wait_done(lat);
    chk("stall_latency", 64'(lat), 64'd32);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("stall_result", result, 64'd143);
      chk("stall_freeze", 64'(freeze), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_a = 32'd3; in_b = 32'd3; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("b2b_valid_drop", 64'(out_valid), 64'd0);
    chk("b2b_freeze", 64'(freeze), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    chk("b2b_latency", 64'(lat), 64'd32);
    chk("b2b_result", result, 64'd9);
    @(negedge clk);

    // Flush on the 10th BUSY cycle
    issue(32'd123, 32'd456, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_freeze", 64'(freeze), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);

    // flush together with in_valid must not accept
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_a = 32'd5; in_b = 32'd5; in_signed = 1'b0;
    @(posedge clk);
    #1;
    chk("flush_acc_freeze", 64'(freeze), 64'd0);
    chk("flush_acc_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    op(32'd2, 32'd2, 1'b0, 64'd4, "u2x2");

    // Asynchronous reset mid-BUSY
    issue(32'd5, 32'd7, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_freeze", 64'(freeze), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
    op(32'd1, 32'd1, 1'b0, 64'd1, "u1x1");

    // Randomized traffic with stalls and occasional flushes
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom % 3) != 0;
      in_a      = pick();
      in_b      = pick();
      in_signed = 1'($urandom);
      flush     = ($urandom % 64) == 0;
      out_ready = ($urandom % 4) != 0;
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
